// File: rtl/arm_mem_pkg.sv
// Shared memory-subsystem definitions: arbiter state encoding, counter width,
// default bus widths and the starvation-counter increment helper.
package arm_mem_pkg;

  localparam int ARB_CNT_W  = 32;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Saturating increment; the count never passes the configured limit.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                     input logic [STARVE_W-1:0] limit);
    return (cnt >= limit) ? limit : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Holds at all-ones once reached; only reset returns it to zero.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Fetch/data arbiter in front of the single SRAM controller port; data wins unless
// fetch has lost STARVE_LIMIT contested rounds. SRAM_ARB_STATS_EN enables the counters.
module sram_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic [ADDR_W-1:0]    i_address,
  output logic [DATA_W-1:0]    i_rdata,
  output logic                 i_ready,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [ADDR_W-1:0]    d_address,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_ready,
  output logic                 sram_read,
  output logic                 sram_write,
  output logic [ADDR_W-1:0]    sram_address,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  input  logic                 sram_ready,
  output logic [ARB_CNT_W-1:0] stat_i_grants,
  output logic [ARB_CNT_W-1:0] stat_d_grants,
  output logic [ARB_CNT_W-1:0] stat_conflicts
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic                sram_read_q, sram_read_d;
  logic                sram_write_q, sram_write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic i_req, d_req, idle, grant_i, grant_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign idle    = (state_q == IDLE);
  assign grant_d = idle & d_req & ~(i_req & (starve_q == LIMIT));
  assign grant_i = idle & i_req & ~grant_d;

  always_comb begin
    state_d      = state_q;
    sram_read_d  = sram_read_q;
    sram_write_d = sram_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_d     = starve_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d      = GRANT_D;
          // A simultaneous read+write is resolved as a write.
          sram_write_d = d_write;
          sram_read_d  = ~d_write;
          addr_d       = d_address;
          wdata_d      = d_wdata;
          if (i_req) begin
            starve_d = starve_inc(starve_q, LIMIT);
          end
        end else if (grant_i) begin
          state_d      = GRANT_I;
          sram_read_d  = 1'b1;
          sram_write_d = 1'b0;
          addr_d       = i_address;
          starve_d     = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (sram_ready) begin
          state_d      = IDLE;
          sram_read_d  = 1'b0;
          sram_write_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        sram_read_d  = 1'b0;
        sram_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sram_read_q  <= 1'b0;
      sram_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_q     <= '0;
    end else begin
      state_q      <= state_d;
      sram_read_q  <= sram_read_d;
      sram_write_q <= sram_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_q     <= starve_d;
    end
  end

  assign sram_read    = sram_read_q;
  assign sram_write   = sram_write_q;
  assign sram_address = addr_q;
  assign sram_wdata   = wdata_q;

  // Completion is returned in the same cycle the controller reports it.
  assign i_ready = (state_q == GRANT_I) & sram_ready;
  assign d_ready = (state_q == GRANT_D) & sram_ready;
  assign i_rdata = sram_rdata;
  assign d_rdata = sram_rdata;

`ifdef SRAM_ARB_STATS_EN
  logic contested;
  assign contested = idle & i_req & d_req;

  sat_counter #(.W(ARB_CNT_W)) u_stat_i (
    .clk(clk), .rst_n(rst), .inc_i(grant_i), .count_o(stat_i_grants)
  );
  sat_counter #(.W(ARB_CNT_W)) u_stat_d (
    .clk(clk), .rst_n(rst), .inc_i(grant_d), .count_o(stat_d_grants)
  );
  sat_counter #(.W(ARB_CNT_W)) u_stat_c (
    .clk(clk), .rst_n(rst), .inc_i(contested), .count_o(stat_conflicts)
  );
`else
  assign stat_i_grants  = '0;
  assign stat_d_grants  = '0;
  assign stat_conflicts = '0;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level arbitration model.
module tb_sram_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;
`ifdef SRAM_ARB_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, sram_ready;
  logic [AW-1:0] i_address, d_address;
  logic [DW-1:0] d_wdata, sram_rdata;
  logic [DW-1:0] i_rdata, d_rdata, sram_wdata;
  logic          i_ready, d_ready, sram_read, sram_write;
  logic [AW-1:0] sram_address;
  logic [31:0]   stat_i_grants, stat_d_grants, stat_conflicts;

  always #5 clk = ~clk;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .sram_read(sram_read), .sram_write(sram_write), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready),
    .stat_i_grants(stat_i_grants), .stat_d_grants(stat_d_grants),
    .stat_conflicts(stat_conflicts)
  );

  int checks = 0;
  int failures = 0;

  // Transaction-level model: one outstanding access, its owner and payload.
  bit          m_busy;
  int          m_owner;    // 0 = fetch, 1 = data
  int          m_lat;      // cycles left before the controller answers
  bit          m_rd, m_wr;
  logic [31:0] m_addr, m_wdata;
  int          m_starve;   // contested data wins since fetch last won
  int          m_ig, m_dg, m_cf;
  int          grant_seq[$];

  function automatic logic [31:0] exp_stat(input int v);
    return STATS_ON ? 32'(v) : 32'd0;
  endfunction

  task automatic set_idle_inputs();
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    sram_ready = 0; sram_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    set_idle_inputs();
    m_busy = 0; m_owner = 0; m_lat = 0; m_rd = 0; m_wr = 0;
    m_addr = '0; m_wdata = '0; m_starve = 0; m_ig = 0; m_dg = 0; m_cf = 0;
    grant_seq.delete();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    set_idle_inputs();
    #3;
    checks++;
    if ({sram_read, sram_write, i_ready, d_ready} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000", {sram_read, sram_write, i_ready, d_ready});
    end
    checks++;
    if ({sram_address, sram_wdata} !== 64'd0) begin
      failures++;
      $display("FAIL reset_bus got=%h/%h exp=0/0", sram_address, sram_wdata);
    end
    checks++;
    if ({stat_i_grants, stat_d_grants, stat_conflicts} !== 96'd0) begin
      failures++;
      $display("FAIL reset_stats got=%0d/%0d/%0d exp=0/0/0",
               stat_i_grants, stat_d_grants, stat_conflicts);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    int wr_cycles = 0;
    int dr_pulses = 0;
    int ir_pulses = 0;
    do_reset();
    @(negedge clk);
    d_write = 1; d_address = 32'h100; d_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (sram_write !== 1'b0) begin
      failures++;
      $display("FAIL wr_grant_latency got=%b exp=0", sram_write);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      sram_ready = (c == 4);
      #1;
      if (sram_write === 1'b1 && sram_read === 1'b0 && sram_address === 32'h100 &&
          sram_wdata === 32'hDEADBEEF) wr_cycles++;
      if (d_ready === 1'b1) dr_pulses++;
      if (i_ready === 1'b1) ir_pulses++;
    end
    @(negedge clk);
    d_write = 0; sram_ready = 0;
    #1;
    if (sram_write === 1'b1) wr_cycles++;
    if (d_ready === 1'b1) dr_pulses++;
    checks++;
    if (wr_cycles != 5) begin
      failures++;
      $display("FAIL wr_hold_cycles got=%0d exp=5", wr_cycles);
    end
    checks++;
    if (dr_pulses != 1 || ir_pulses != 0) begin
      failures++;
      $display("FAIL wr_ready_pulses got d=%0d i=%0d exp d=1 i=0", dr_pulses, ir_pulses);
    end
    checks++;
    if (stat_d_grants !== exp_stat(1) || stat_i_grants !== exp_stat(0)) begin
      failures++;
      $display("FAIL wr_stats got=%0d/%0d exp=%0d/%0d",
               stat_i_grants, stat_d_grants, exp_stat(0), exp_stat(1));
    end
  endtask

  task automatic test_conflict();
    do_reset();
    @(negedge clk);
    i_read = 1; i_address = 32'h40; d_read = 1; d_address = 32'h80;
    @(negedge clk);
    sram_ready = 1;
    #1;
    checks++;
    if ({sram_read, sram_address, d_ready, i_ready} !== {1'b1, 32'h80, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL conflict_first got rd=%b a=%h dr=%b ir=%b exp rd=1 a=80 dr=1 ir=0",
               sram_read, sram_address, d_ready, i_ready);
    end
    @(negedge clk);
    d_read = 0; sram_ready = 0;
    #1;
    checks++;
    if (sram_read !== 1'b0) begin
      failures++;
      $display("FAIL conflict_idle_gap got=%b exp=0", sram_read);
    end
    @(negedge clk);
    sram_ready = 1;
    #1;
    checks++;
    if ({sram_read, sram_address, i_ready, d_ready} !== {1'b1, 32'h40, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL conflict_second got rd=%b a=%h ir=%b dr=%b exp rd=1 a=40 ir=1 dr=0",
               sram_read, sram_address, i_ready, d_ready);
    end
    @(negedge clk);
    i_read = 0; sram_ready = 0;
    #1;
    checks++;
    if ({stat_i_grants, stat_d_grants, stat_conflicts} !==
        {exp_stat(1), exp_stat(1), exp_stat(1)}) begin
      failures++;
      $display("FAIL conflict_stats got=%0d/%0d/%0d exp=%0d/%0d/%0d", stat_i_grants,
               stat_d_grants, stat_conflicts, exp_stat(1), exp_stat(1), exp_stat(1));
    end
  endtask

  task automatic test_illegal_rw();
    do_reset();
    @(negedge clk);
    d_read = 1; d_write = 1; d_address = 32'h3C; d_wdata = 32'h1234_5678;
    @(negedge clk);
    sram_ready = 1;
    #1;
    checks++;
    if ({sram_write, sram_read, sram_wdata} !== {1'b1, 1'b0, 32'h1234_5678}) begin
      failures++;
      $display("FAIL illegal_rw got wr=%b rd=%b wd=%h exp wr=1 rd=0 wd=12345678",
               sram_write, sram_read, sram_wdata);
    end
    @(negedge clk);
    d_read = 0; d_write = 0; sram_ready = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    d_read = 1; d_address = 32'h200;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 0; sram_ready = 1;
    #1;
    checks++;
    if ({sram_read, d_ready, i_ready} !== 3'b000 || sram_address !== '0) begin
      failures++;
      $display("FAIL midreset_clear got rd=%b dr=%b ir=%b a=%h exp 0/0/0/0",
               sram_read, d_ready, i_ready, sram_address);
    end
    checks++;
    if (stat_d_grants !== 32'd0) begin
      failures++;
      $display("FAIL midreset_stats got=%0d exp=0", stat_d_grants);
    end
    @(negedge clk);
    rst = 1; sram_ready = 0;
    #1;
    checks++;
    if (sram_read !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle got=%b exp=0", sram_read);
    end
    @(negedge clk);
    sram_ready = 1;
    #1;
    checks++;
    if ({sram_read, sram_address, d_ready} !== {1'b1, 32'h200, 1'b1}) begin
      failures++;
      $display("FAIL midreset_regrant got rd=%b a=%h dr=%b exp rd=1 a=200 dr=1",
               sram_read, sram_address, d_ready);
    end
    @(negedge clk);
    d_read = 0; sram_ready = 0;
  endtask

  task automatic test_idle_ready();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      sram_ready = (c % 2 == 0);
      sram_rdata = $urandom;
      #1;
      checks++;
      if ({i_ready, d_ready, sram_read, sram_write} !== 4'b0) begin
        failures++;
        $display("FAIL idle_ready c=%0d got=%b exp=0000", c,
                 {i_ready, d_ready, sram_read, sram_write});
      end
    end
    checks++;
    if ({stat_i_grants, stat_d_grants, stat_conflicts} !== 96'd0) begin
      failures++;
      $display("FAIL idle_stats got=%0d/%0d/%0d exp=0/0/0",
               stat_i_grants, stat_d_grants, stat_conflicts);
    end
    sram_ready = 0;
  endtask

  // saturate=1: both sides re-request immediately after every completion.
  task automatic run_traffic(input int n_cycles, input bit saturate);
    bit   i_done = 0;
    bit   d_done = 0;
    bit   ireq, dreq, exp_ir, exp_dr;
    int   k;
    for (int c = 0; c < n_cycles; c++) begin
      @(negedge clk);
      if (i_done ? (saturate || $urandom_range(1) == 1)
                 : (!i_read && (saturate || $urandom_range(3) == 0))) begin
        i_read = 1; i_address = $urandom;
      end else if (i_done) begin
        i_read = 0;
      end
      if (d_done ? (saturate || $urandom_range(1) == 1)
                 : (!(d_read || d_write) && (saturate || $urandom_range(3) == 0))) begin
        k = $urandom_range(2);
        d_read = (k != 1); d_write = (k != 0);
        d_address = $urandom; d_wdata = $urandom;
      end else if (d_done) begin
        d_read = 0; d_write = 0;
      end
      sram_ready = m_busy ? (m_lat == 0) : ($urandom_range(7) == 0);
      sram_rdata = $urandom;
      #1;
      exp_ir = m_busy && m_owner == 0 && sram_ready;
      exp_dr = m_busy && m_owner == 1 && sram_ready;
      checks++;
      if ({sram_read, sram_write, i_ready, d_ready} !==
          {m_busy && m_rd, m_busy && m_wr, exp_ir, exp_dr}) begin
        failures++;
        $display("FAIL traffic_ctrl c=%0d got rd/wr/ir/dr=%b exp=%b", c,
                 {sram_read, sram_write, i_ready, d_ready},
                 {m_busy && m_rd, m_busy && m_wr, exp_ir, exp_dr});
      end
      if (m_busy) begin
        checks++;
        if (sram_address !== m_addr || (m_wr && sram_wdata !== m_wdata)) begin
          failures++;
          $display("FAIL traffic_bus c=%0d got a=%h wd=%h exp a=%h wd=%h", c,
                   sram_address, sram_wdata, m_addr, m_wdata);
        end
      end
      if (exp_ir || exp_dr) begin
        checks++;
        if ((exp_ir ? i_rdata : d_rdata) !== sram_rdata) begin
          failures++;
          $display("FAIL traffic_rdata c=%0d got=%h exp=%h", c,
                   exp_ir ? i_rdata : d_rdata, sram_rdata);
        end
      end
      checks++;
      if ({stat_i_grants, stat_d_grants, stat_conflicts} !==
          {exp_stat(m_ig), exp_stat(m_dg), exp_stat(m_cf)}) begin
        failures++;
        $display("FAIL traffic_stats c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                 stat_i_grants, stat_d_grants, stat_conflicts,
                 exp_stat(m_ig), exp_stat(m_dg), exp_stat(m_cf));
      end
      i_done = exp_ir;
      d_done = exp_dr;
      if (m_busy) begin
        if (sram_ready) m_busy = 0;
        else m_lat--;
      end else begin
        ireq = i_read;
        dreq = d_read || d_write;
        if (ireq && dreq) m_cf++;
        if (dreq && !(ireq && m_starve == LIMIT)) begin
          m_busy = 1; m_owner = 1; m_wr = d_write; m_rd = !d_write;
          m_addr = d_address; m_wdata = d_wdata; m_dg++;
          if (ireq && m_starve < LIMIT) m_starve++;
          grant_seq.push_back(1);
        end else if (ireq) begin
          m_busy = 1; m_owner = 0; m_rd = 1; m_wr = 0;
          m_addr = i_address; m_starve = 0; m_ig++;
          grant_seq.push_back(0);
        end
        m_lat = saturate ? $urandom_range(3) : $urandom_range(4);
      end
    end
  endtask

  task automatic test_random_traffic();
    do_reset();
    run_traffic(500, 1'b0);
  endtask

  task automatic test_starvation();
    do_reset();
    run_traffic(240, 1'b1);
    checks++;
    if (grant_seq.size() < 20) begin
      failures++;
      $display("FAIL starve_progress got=%0d grants exp>=20", grant_seq.size());
    end
    foreach (grant_seq[k]) begin
      checks++;
      if (grant_seq[k] != ((k % (LIMIT + 1) == LIMIT) ? 0 : 1)) begin
        failures++;
        $display("FAIL starve_pattern idx=%0d got=%s exp=%s", k,
                 grant_seq[k] ? "D" : "I", (k % (LIMIT + 1) == LIMIT) ? "I" : "D");
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_conflict();
    test_illegal_rw();
    test_reset_mid();
    test_idle_ready();
    test_random_traffic();
    test_starvation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter sharing the single SRAM_Controller request interface between the instruction-fetch side (read-only) and the data side (cache controller, read/write). It sits between the requesters and SRAM_Controller and latches the winning request. It holds it on the SRAM interface until `sram_ready`, then routes the completion back to the winner. Fixed data-over-instruction priority applies, with a starvation guard so fetch always progresses.

## Interface
- `ADDR_W`, 32, address width of all ports
- `DATA_W`, 32, data width of all ports
- `STARVE_LIMIT`, 4, consecutive contested data grants before instruction side is forced to win (1..15)
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_read`  in  1  instruction read request, level, held until `i_ready`
- `i_address`  in  ADDR_W  instruction address
- `i_rdata`  out  DATA_W  read data, valid when `i_ready`
- `i_ready`  out  1  one-cycle completion pulse to instruction side
- `d_read`, `d_write`  in  1  data request levels, held until `d_ready`
- `d_address`  in  ADDR_W;  `d_wdata`  in  DATA_W
- `d_rdata`  out  DATA_W;  `d_ready`  out  1  as instruction side
- `sram_read`, `sram_write`  out  1  request to SRAM_Controller, registered
- `sram_address`  out  ADDR_W;  `sram_wdata`  out  DATA_W  registered
- `sram_rdata`  in  DATA_W;  `sram_ready`  in  1  controller completion pulse
- `stat_i_grants`, `stat_d_grants`, `stat_conflicts`  out  32  performance counters

## Operation
- States: IDLE, GRANT_I, GRANT_D.
- IDLE: no requests, stay. Only instruction requests, GRANT_I. Only data requests (`d_read|d_write`), GRANT_D. Both: GRANT_D unless `starve_cnt == STARVE_LIMIT`, then GRANT_I.
- On the IDLE->GRANT edge, latch the winner's address, and wdata for data. Drive `sram_read`/`sram_write` from registers.
- `d_read & d_write` together is illegal. Treat it as write only.
- GRANT_x: hold the latched outputs while `sram_ready=0`. On `sram_ready=1`:
  - `x_ready=1` combinationally in that cycle.
  - Clear `sram_read`/`sram_write` at the edge.
  - Return to IDLE.
- `sram_ready` in IDLE is ignored. Neither ready pulses.
- `i_rdata = d_rdata = sram_rdata`, unqualified. Requesters qualify with ready.
- `starve_cnt` (4 bits):
  - Increments when GRANT_D is entered with `i_read` high.
  - Clears when GRANT_I is entered.
  - Never exceeds STARVE_LIMIT.
- Requester contract: deassert or present a new request in the cycle after ready. A level still high in IDLE is a new transaction.
- Request changes while not granted are not latched. Only the IDLE-cycle values count.

## Timing
- Grant latency: request visible in IDLE at cycle t, `sram_read`/`sram_write` high from cycle t+1.
- Completion: `sram_ready` at cycle k gives `x_ready` at cycle k (zero added latency). IDLE resumes at k+1.
- Back-to-back transactions: minimum one IDLE cycle between transactions, so the next grant is at k+2.
- Reset (async, mid-transaction included):
  - State IDLE; `sram_read`, `sram_write`, `sram_address`, `sram_wdata`, `starve_cnt` and all stat counters are 0.
  - `i_ready`/`d_ready` go 0 immediately.
  - An in-flight SRAM access is abandoned. SRAM_Controller shares the reset.

## Configuration
- `SRAM_ARB_STATS_EN` defined:
  - `stat_i_grants` increments on each GRANT_I entry.
  - `stat_d_grants` increments on each GRANT_D entry.
  - `stat_conflicts` increments on each IDLE cycle with both sides requesting.
  - All saturate at 0xFFFFFFFF and clear only on reset.
- Undefined: no counter flops. The three outputs are tied to 0 and the port list is unchanged.

## Structure
- Shared package `arm_mem_pkg`: state enum (IDLE/GRANT_I/GRANT_D), `ARB_CNT_W=32`, default address/data widths. The same package is reused by the cache and SRAM controllers.
- One sub-module: `sat_counter` (parameterised width, inc, async active-low clear, saturation), instantiated three times under the macro.

## Test plan
- Only `d_write` at 0x100, wdata 0xDEADBEEF; controller ready after 5 cycles -> `sram_write` high 5 cycles with those values, one `d_ready` pulse, `i_ready` stays 0.
- `i_read`@0x40 and `d_read`@0x80 together, STARVE_LIMIT=4 -> data granted first, then fetch; `stat_conflicts`=1.
- Both sides continuously requesting, STARVE_LIMIT=4 -> grant sequence D,D,D,D,I repeating; fetch never waits more than 4 data transactions.
- `d_read` and `d_write` both high -> `sram_write=1`, `sram_read=0`.
- Reset asserted 2 cycles into a GRANT_D read -> immediately `sram_read=0`, `d_ready=0`, state IDLE. After release, a held `d_read` is re-granted at cycle t+1.
- `sram_ready` pulsed in IDLE with no requests -> no ready pulse, state unchanged. With the macro off, stat outputs stay 0 throughout.
